// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequencer between execute and the memory access unit. Accepts one
//            load/store request, forms the effective address, drives and holds
//            the memory unit's operation inputs, then returns a one-cycle
//            completion record (result or trap) to writeback.
// Ports    : clk, reset (synchronous, active-low)
//            req_*    - request from execute (sampled only in IDLE)
//            mem_*    - operation to / status from the memory access unit
//            done, rd_write, rd_out, result, trap, trap_cause, trap_value
//                     - completion record, valid for the single done cycle
// Options  : LSU_TIMEOUT_EN - when defined, WAIT aborts with an access fault
//            after TIMEOUT_CYCLES busy cycles (legal range 1..255).
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic        req_is_unsigned,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_rd,
    output logic        mem_available,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_busy,
    input  logic        mem_op_fault,
    input  logic        mem_addr_fault,
    input  logic        mem_access_fault,
    output logic        done,
    output logic        rd_write,
    output logic [4:0]  rd_out,
    output logic [31:0] result,
    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_value
);

    // Exception codes reported in trap_cause
    localparam logic [3:0] c_cause_op        = 4'd2;
    localparam logic [3:0] c_cause_ld_addr   = 4'd4;
    localparam logic [3:0] c_cause_ld_access = 4'd5;
    localparam logic [3:0] c_cause_st_addr   = 4'd6;
    localparam logic [3:0] c_cause_st_access = 4'd7;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
            $error("load_store_unit: TIMEOUT_CYCLES must be within 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CHECK = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_rd;

    logic        w_req_ready_nxt;
    logic        w_mem_available_nxt;
    logic        w_mem_is_write_nxt;
    logic        w_mem_is_unsigned_nxt;
    logic [1:0]  w_mem_op_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_in_nxt;
    logic [4:0]  w_rd_nxt;
    logic        w_done_nxt;
    logic        w_rd_write_nxt;
    logic [4:0]  w_rd_out_nxt;
    logic [31:0] w_result_nxt;
    logic        w_trap_nxt;
    logic [3:0]  w_trap_cause_nxt;
    logic [31:0] w_trap_value_nxt;

    // Completion requests raised by CHECK/WAIT; folded into DONE entry below
    logic        w_finish_ok;
    logic        w_finish_trap;
    logic [3:0]  w_cause;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt           = r_state;
        w_req_ready_nxt       = req_ready;
        w_mem_available_nxt   = mem_available;
        w_mem_is_write_nxt    = mem_is_write;
        w_mem_is_unsigned_nxt = mem_is_unsigned;
        w_mem_op_nxt          = mem_op;
        w_mem_addr_nxt        = mem_addr;
        w_mem_in_nxt          = mem_in;
        w_rd_nxt              = r_rd;
        // Completion record fields are pulses: zero unless entering DONE
        w_done_nxt            = 1'b0;
        w_rd_write_nxt        = 1'b0;
        w_rd_out_nxt          = 5'd0;
        w_result_nxt          = 32'd0;
        w_trap_nxt            = 1'b0;
        w_trap_cause_nxt      = 4'd0;
        w_trap_value_nxt      = 32'd0;
        w_finish_ok           = 1'b0;
        w_finish_trap         = 1'b0;
        w_cause               = 4'd0;
`ifdef LSU_TIMEOUT_EN
        w_wait_cnt_nxt        = r_wait_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt     = 1'b1;
                w_mem_available_nxt = 1'b0;
                if (req_valid) begin
                    w_state_nxt           = S_ISSUE;
                    w_req_ready_nxt       = 1'b0;
                    w_mem_available_nxt   = 1'b1;
                    w_mem_is_write_nxt    = req_is_store;
                    w_mem_is_unsigned_nxt = req_is_unsigned;
                    w_mem_op_nxt          = req_op;
                    // Wraps modulo 2^32 by construction of the 32-bit add
                    w_mem_addr_nxt        = req_base + {{20{req_offset[11]}}, req_offset};
                    w_mem_in_nxt          = req_data;
                    w_rd_nxt              = req_rd;
                end
            end

            // The memory unit samples the operation here; its status is only
            // meaningful one cycle later.
            S_ISSUE: begin
                w_state_nxt = S_CHECK;
            end

            S_CHECK: begin
                if (mem_op_fault) begin
                    w_finish_trap = 1'b1;
                    w_cause       = c_cause_op;
                end else if (mem_addr_fault) begin
                    w_finish_trap = 1'b1;
                    w_cause       = mem_is_write ? c_cause_st_addr : c_cause_ld_addr;
                end else if (mem_access_fault) begin
                    w_finish_trap = 1'b1;
                    w_cause       = mem_is_write ? c_cause_st_access : c_cause_ld_access;
                end else if (mem_busy) begin
                    w_state_nxt = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                    w_wait_cnt_nxt = 8'd0;
`endif
                end else begin
                    w_finish_ok = 1'b1;
                end
            end

            S_WAIT: begin
                if (!mem_busy) begin
                    w_finish_ok = 1'b1;
                end
`ifdef LSU_TIMEOUT_EN
                else if (r_wait_cnt == c_timeout_last) begin
                    w_finish_trap = 1'b1;
                    w_cause       = mem_is_write ? c_cause_st_access : c_cause_ld_access;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
`endif
            end

            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end

            default: begin
                w_state_nxt         = S_IDLE;
                w_req_ready_nxt     = 1'b1;
                w_mem_available_nxt = 1'b0;
            end
        endcase

        // Entering DONE: mem_available drops for one cycle so the memory unit
        // sees a clean gap between operations.
        if (w_finish_ok || w_finish_trap) begin
            w_state_nxt         = S_DONE;
            w_mem_available_nxt = 1'b0;
            w_done_nxt          = 1'b1;
            w_rd_out_nxt        = r_rd;
            w_trap_nxt          = w_finish_trap;
            w_trap_cause_nxt    = w_cause;
            w_trap_value_nxt    = w_finish_trap ? mem_addr : 32'd0;
            w_rd_write_nxt      = w_finish_ok && !mem_is_write && (r_rd != 5'd0);
            w_result_nxt        = (w_finish_ok && !mem_is_write) ? mem_out : 32'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs and latched request fields
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready       <= 1'b1;
            mem_available   <= 1'b0;
            mem_is_write    <= 1'b0;
            mem_is_unsigned <= 1'b0;
            mem_op          <= 2'd0;
            mem_addr        <= 32'd0;
            mem_in          <= 32'd0;
            r_rd            <= 5'd0;
            done            <= 1'b0;
            rd_write        <= 1'b0;
            rd_out          <= 5'd0;
            result          <= 32'd0;
            trap            <= 1'b0;
            trap_cause      <= 4'd0;
            trap_value      <= 32'd0;
        end else begin
            req_ready       <= w_req_ready_nxt;
            mem_available   <= w_mem_available_nxt;
            mem_is_write    <= w_mem_is_write_nxt;
            mem_is_unsigned <= w_mem_is_unsigned_nxt;
            mem_op          <= w_mem_op_nxt;
            mem_addr        <= w_mem_addr_nxt;
            mem_in          <= w_mem_in_nxt;
            r_rd            <= w_rd_nxt;
            done            <= w_done_nxt;
            rd_write        <= w_rd_write_nxt;
            rd_out          <= w_rd_out_nxt;
            result          <= w_result_nxt;
            trap            <= w_trap_nxt;
            trap_cause      <= w_trap_cause_nxt;
            trap_value      <= w_trap_value_nxt;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit. The memory
//            unit is modelled by driving busy/fault/read-data directly,
//            counted in cycles from the CHECK cycle onward.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic        req_is_unsigned;
    logic [1:0]  req_op;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_data;
    logic [4:0]  req_rd;
    logic        mem_available;
    logic        mem_is_write;
    logic        mem_is_unsigned;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        mem_busy;
    logic        mem_op_fault;
    logic        mem_addr_fault;
    logic        mem_access_fault;
    logic        done;
    logic        rd_write;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_value;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by run_op for the scenario tasks to judge
    logic [31:0] obs_issue_addr;
    logic [31:0] obs_issue_in;
    logic [1:0]  obs_issue_op;
    logic        obs_issue_write;
    logic        obs_issue_unsigned;
    logic        obs_issue_avail;
    logic        obs_issue_ready;
    logic        obs_stable;
    logic        obs_got;
    int          obs_done_k;
    logic        obs_rd_write;
    logic [4:0]  obs_rd_out;
    logic [31:0] obs_result;
    logic        obs_trap;
    logic [3:0]  obs_trap_cause;
    logic [31:0] obs_trap_value;
    logic        obs_done_avail;
    logic        obs_after_done;
    logic        obs_after_ready;
    logic        obs_after_avail;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_is_unsigned  (req_is_unsigned),
        .req_op           (req_op),
        .req_base         (req_base),
        .req_offset       (req_offset),
        .req_data         (req_data),
        .req_rd           (req_rd),
        .mem_available    (mem_available),
        .mem_is_write     (mem_is_write),
        .mem_is_unsigned  (mem_is_unsigned),
        .mem_op           (mem_op),
        .mem_addr         (mem_addr),
        .mem_in           (mem_in),
        .mem_out          (mem_out),
        .mem_busy         (mem_busy),
        .mem_op_fault     (mem_op_fault),
        .mem_addr_fault   (mem_addr_fault),
        .mem_access_fault (mem_access_fault),
        .done             (done),
        .rd_write         (rd_write),
        .rd_out           (rd_out),
        .result           (result),
        .trap             (trap),
        .trap_cause       (trap_cause),
        .trap_value       (trap_value)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays the memory unit: busy for busy_cycles
    // cycles counted from CHECK (k=1), fault flags presented in CHECK only.
    task automatic run_op(input logic st, input logic uns, input logic [1:0] op,
                          input logic [31:0] base, input logic [11:0] off,
                          input logic [31:0] data, input logic [4:0] rd,
                          input int busy_cycles, input logic opf, input logic adf,
                          input logic acf, input logic [31:0] mdata,
                          input logic hold_valid);
        int k;
        req_valid       = 1'b1;
        req_is_store    = st;
        req_is_unsigned = uns;
        req_op          = op;
        req_base        = base;
        req_offset      = off;
        req_data        = data;
        req_rd          = rd;
        tick;
        obs_issue_addr     = mem_addr;
        obs_issue_in       = mem_in;
        obs_issue_op       = mem_op;
        obs_issue_write    = mem_is_write;
        obs_issue_unsigned = mem_is_unsigned;
        obs_issue_avail    = mem_available;
        obs_issue_ready    = req_ready;
        if (hold_valid) begin
            // Different request held on the bus; must be ignored
            req_base     = 32'hABCD_0000;
            req_offset   = 12'h123;
            req_is_store = ~st;
            req_op       = ~op;
            req_rd       = 5'd9;
        end else begin
            req_valid = 1'b0;
        end
        mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
        mem_out  = mdata;
        obs_stable = 1'b1;
        obs_got    = 1'b0;
        obs_done_k = 0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (!obs_got) begin
                tick;
                k++;
                if (done === 1'b1) begin
                    obs_got        = 1'b1;
                    obs_done_k     = k;
                    obs_rd_write   = rd_write;
                    obs_rd_out     = rd_out;
                    obs_result     = result;
                    obs_trap       = trap;
                    obs_trap_cause = trap_cause;
                    obs_trap_value = trap_value;
                    obs_done_avail = mem_available;
                end else begin
                    if (mem_addr !== obs_issue_addr || mem_op !== obs_issue_op ||
                        mem_in !== obs_issue_in || mem_available !== 1'b1)
                        obs_stable = 1'b0;
                    mem_busy         = (k <= busy_cycles);
                    mem_op_fault     = (k == 1) && opf;
                    mem_addr_fault   = (k == 1) && adf;
                    mem_access_fault = (k == 1) && acf;
                end
            end
        end
        req_valid = 1'b0;
        mem_busy = 1'b0; mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
        mem_out  = 32'd0;
        tick;
        obs_after_done  = done;
        obs_after_ready = req_ready;
        obs_after_avail = mem_available;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (mem_available !== 1'b0) begin n_fail++; $display("FAIL reset_mem_available: got %b expected 0", mem_available); end
        n_checks++; if (done !== 1'b0 || trap !== 1'b0 || rd_write !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b trap=%b rd_write=%b expected 0", done, trap, rd_write); end
        n_checks++; if (mem_addr !== 32'd0 || result !== 32'd0 || trap_value !== 32'd0) begin n_fail++; $display("FAIL reset_data: got addr=%h result=%h tval=%h expected 0", mem_addr, result, trap_value); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_wait;
        logic saw_done;
        req_valid = 1'b1; req_is_store = 1'b0; req_is_unsigned = 1'b0; req_op = 2'b10;
        req_base = 32'h0000_4000; req_offset = 12'h004; req_data = 32'd0; req_rd = 5'd3;
        tick;
        req_valid = 1'b0;
        mem_busy  = 1'b1;
        tick; tick; tick; tick;   // CHECK then WAIT cycles
        n_checks++; if (mem_available !== 1'b1) begin n_fail++; $display("FAIL wait_available: got %b expected 1", mem_available); end
        reset = 1'b0;
        tick;
        tick;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (mem_available !== 1'b0) begin n_fail++; $display("FAIL midreset_available: got %b expected 0", mem_available); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        reset    = 1'b1;
        mem_busy = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b expected 0", saw_done); end
    endtask

    task automatic test_load_word;
        run_op(1'b0, 1'b0, 2'b10, 32'h0000_1000, 12'hFFC, 32'd0, 5'd5, 3,
               1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        n_checks++; if (obs_issue_addr !== 32'h0000_0FFC) begin n_fail++; $display("FAIL lw_addr: got %h expected 00000ffc", obs_issue_addr); end
        n_checks++; if (obs_issue_avail !== 1'b1 || obs_issue_ready !== 1'b0) begin n_fail++; $display("FAIL lw_issue: got avail=%b ready=%b expected 1/0", obs_issue_avail, obs_issue_ready); end
        n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL lw_stable: got %b expected 1", obs_stable); end
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 5) begin n_fail++; $display("FAIL lw_latency: got done=%b at k=%0d expected 1 at k=5", obs_got, obs_done_k); end
        n_checks++; if (obs_rd_write !== 1'b1 || obs_rd_out !== 5'd5) begin n_fail++; $display("FAIL lw_rd: got wr=%b rd=%0d expected 1/5", obs_rd_write, obs_rd_out); end
        n_checks++; if (obs_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_result: got %h expected deadbeef", obs_result); end
        n_checks++; if (obs_trap !== 1'b0) begin n_fail++; $display("FAIL lw_trap: got %b expected 0", obs_trap); end
        n_checks++; if (obs_done_avail !== 1'b0) begin n_fail++; $display("FAIL lw_done_avail: got %b expected 0", obs_done_avail); end
        n_checks++; if (obs_after_done !== 1'b0 || obs_after_ready !== 1'b1) begin n_fail++; $display("FAIL lw_after: got done=%b ready=%b expected 0/1", obs_after_done, obs_after_ready); end
    endtask

    task automatic test_store_fault;
        run_op(1'b1, 1'b0, 2'b01, 32'h0000_2001, 12'h000, 32'h0000_1234, 5'd7, 0,
               1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        n_checks++; if (obs_issue_write !== 1'b1 || obs_issue_op !== 2'b01 || obs_issue_in !== 32'h0000_1234) begin n_fail++; $display("FAIL sh_issue: got wr=%b op=%b in=%h expected 1/01/00001234", obs_issue_write, obs_issue_op, obs_issue_in); end
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 2) begin n_fail++; $display("FAIL sh_latency: got done=%b at k=%0d expected 1 at k=2", obs_got, obs_done_k); end
        n_checks++; if (obs_trap !== 1'b1 || obs_trap_cause !== 4'd6) begin n_fail++; $display("FAIL sh_cause: got trap=%b cause=%0d expected 1/6", obs_trap, obs_trap_cause); end
        n_checks++; if (obs_trap_value !== 32'h0000_2001) begin n_fail++; $display("FAIL sh_tval: got %h expected 00002001", obs_trap_value); end
        n_checks++; if (obs_rd_write !== 1'b0 || obs_result !== 32'd0) begin n_fail++; $display("FAIL sh_wb: got wr=%b result=%h expected 0/0", obs_rd_write, obs_result); end
    endtask

    task automatic test_op_fault;
        run_op(1'b0, 1'b0, 2'b11, 32'h0000_3000, 12'h010, 32'd0, 5'd4, 0,
               1'b1, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
        n_checks++; if (obs_trap !== 1'b1 || obs_trap_cause !== 4'd2) begin n_fail++; $display("FAIL opf_cause: got trap=%b cause=%0d expected 1/2", obs_trap, obs_trap_cause); end
        n_checks++; if (obs_trap_value !== 32'h0000_3010) begin n_fail++; $display("FAIL opf_tval: got %h expected 00003010", obs_trap_value); end
        n_checks++; if (obs_rd_write !== 1'b0 || obs_result !== 32'd0) begin n_fail++; $display("FAIL opf_wb: got wr=%b result=%h expected 0/0", obs_rd_write, obs_result); end
    endtask

    task automatic test_load_access_fault;
        run_op(1'b0, 1'b1, 2'b01, 32'h0000_0010, 12'h800, 32'd0, 5'd8, 0,
               1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        n_checks++; if (obs_issue_addr !== 32'hFFFF_F810 || obs_issue_unsigned !== 1'b1) begin n_fail++; $display("FAIL lhu_issue: got addr=%h uns=%b expected fffff810/1", obs_issue_addr, obs_issue_unsigned); end
        n_checks++; if (obs_trap !== 1'b1 || obs_trap_cause !== 4'd5 || obs_trap_value !== 32'hFFFF_F810) begin n_fail++; $display("FAIL lhu_trap: got trap=%b cause=%0d tval=%h expected 1/5/fffff810", obs_trap, obs_trap_cause, obs_trap_value); end
    endtask

    task automatic test_wrap;
        run_op(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 12'h001, 32'd0, 5'd0, 0,
               1'b0, 1'b0, 1'b0, 32'h0000_0080, 1'b0);
        n_checks++; if (obs_issue_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", obs_issue_addr); end
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 2) begin n_fail++; $display("FAIL wrap_latency: got done=%b at k=%0d expected 1 at k=2", obs_got, obs_done_k); end
        n_checks++; if (obs_rd_write !== 1'b0 || obs_trap !== 1'b0) begin n_fail++; $display("FAIL wrap_wb: got wr=%b trap=%b expected 0/0", obs_rd_write, obs_trap); end
    endtask

    task automatic test_store_ignore_req;
        // Store with held, changing request bus: operation must stay intact
        run_op(1'b1, 1'b0, 2'b10, 32'h0000_0100, 12'h7FF, 32'hCAFE_F00D, 5'd12, 1,
               1'b0, 1'b0, 1'b0, 32'h5555_5555, 1'b1);
        n_checks++; if (obs_issue_addr !== 32'h0000_08FF || obs_issue_in !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_issue: got addr=%h in=%h expected 000008ff/cafef00d", obs_issue_addr, obs_issue_in); end
        n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL sw_ignore_req: got stable=%b expected 1", obs_stable); end
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 3) begin n_fail++; $display("FAIL sw_latency: got done=%b at k=%0d expected 1 at k=3", obs_got, obs_done_k); end
        n_checks++; if (obs_result !== 32'd0 || obs_rd_write !== 1'b0 || obs_trap !== 1'b0 || obs_rd_out !== 5'd12) begin n_fail++; $display("FAIL sw_record: got result=%h wr=%b trap=%b rd=%0d expected 0/0/0/12", obs_result, obs_rd_write, obs_trap, obs_rd_out); end
        n_checks++; if (obs_after_avail !== 1'b0 || obs_after_ready !== 1'b1) begin n_fail++; $display("FAIL sw_after: got avail=%b ready=%b expected 0/1", obs_after_avail, obs_after_ready); end
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 1'b0, 2'b10, 32'h0000_0200, 12'h008, 32'd0, 5'd1, 0,
               1'b0, 1'b0, 1'b0, 32'h0102_0304, 1'b0);
        n_checks++; if (obs_result !== 32'h0102_0304 || obs_rd_out !== 5'd1) begin n_fail++; $display("FAIL b2b_first: got result=%h rd=%0d expected 01020304/1", obs_result, obs_rd_out); end
        run_op(1'b0, 1'b0, 2'b10, 32'h0000_0300, 12'hFF0, 32'd0, 5'd31, 2,
               1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0);
        n_checks++; if (obs_issue_addr !== 32'h0000_02F0) begin n_fail++; $display("FAIL b2b_addr: got %h expected 000002f0", obs_issue_addr); end
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 4 || obs_result !== 32'hA5A5_5A5A || obs_rd_write !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got done=%b k=%0d result=%h wr=%b expected 1/4/a5a55a5a/1", obs_got, obs_done_k, obs_result, obs_rd_write); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout;
        run_op(1'b0, 1'b0, 2'b10, 32'h0000_5000, 12'h000, 32'd0, 5'd6, 1000,
               1'b0, 1'b0, 1'b0, 32'h7777_7777, 1'b0);
        n_checks++; if (obs_got !== 1'b1 || obs_done_k != 6) begin n_fail++; $display("FAIL to_latency: got done=%b at k=%0d expected 1 at k=6", obs_got, obs_done_k); end
        n_checks++; if (obs_trap !== 1'b1 || obs_trap_cause !== 4'd5 || obs_trap_value !== 32'h0000_5000) begin n_fail++; $display("FAIL to_trap: got trap=%b cause=%0d tval=%h expected 1/5/00005000", obs_trap, obs_trap_cause, obs_trap_value); end
        n_checks++; if (obs_done_avail !== 1'b0 || obs_rd_write !== 1'b0) begin n_fail++; $display("FAIL to_done: got avail=%b wr=%b expected 0/0", obs_done_avail, obs_rd_write); end
        run_op(1'b0, 1'b0, 2'b10, 32'h0000_6000, 12'h000, 32'd0, 5'd6, 0,
               1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE, 1'b0);
        n_checks++; if (obs_got !== 1'b1 || obs_result !== 32'h0BAD_CAFE || obs_trap !== 1'b0) begin n_fail++; $display("FAIL to_next: got done=%b result=%h trap=%b expected 1/0badcafe/0", obs_got, obs_result, obs_trap); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_is_unsigned = 1'b0; req_op = 2'b00;
        req_base = 32'd0; req_offset = 12'd0; req_data = 32'd0; req_rd = 5'd0;
        mem_out = 32'd0; mem_busy = 1'b0;
        mem_op_fault = 1'b0; mem_addr_fault = 1'b0; mem_access_fault = 1'b0;
        test_reset;
        test_load_word;
        test_store_fault;
        test_op_fault;
        test_load_access_fault;
        test_wrap;
        test_store_ignore_req;
        test_back_to_back;
`ifdef LSU_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
